// File: rtl/vga_obstacle_mapper.sv
// Palette-to-RGB mapper for the ducking-duck VGA path, with NOBJ falling obstacles and button scoring.
// Build option: define SCORE_BCD_EN for a packed-BCD score (saturates at 9999); otherwise binary (saturates at FFFF).
module vga_obstacle_mapper #(
  parameter int CIDXW     = 3,
  parameter int NOBJ      = 3,
  parameter int SPEED_DIV = 500000,
  parameter int YWRAP     = 779,
  parameter int Y0        = 320,
  parameter int Y_SPACING = 100,
  parameter int X0        = 340,
  parameter int X_STEP    = 80,
  parameter int OBJ_W     = 40,
  parameter int OBJ_H     = 40,
  parameter int HIT_LO    = 400,
  parameter int HIT_HI    = 475,
  parameter int REARM_Y   = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               bright,
  input  logic               drawing,
  input  logic [CIDXW:0]     pix,
  input  logic [9:0]         hCount,
  input  logic [9:0]         vCount,
  input  logic               button,
  output logic [11:0]        rgb,
  output logic [15:0]        score,
  output logic [10*NOBJ-1:0] obj_y
);

  localparam int DIVW = $clog2(SPEED_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SPEED_DIV - 1);

  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_SCORED = 1'b1
  } hit_state_t;

  logic [DIVW-1:0] div_r;
  logic            tick_s;
  logic            sync1_r;
  logic            sync2_r;
  logic            sync2_d_r;
  logic            press_s;
  logic [9:0]      obj_y_r [NOBJ];
  hit_state_t      hit_state_r [NOBJ];
  hit_state_t      hit_state_s [NOBJ];
  logic [NOBJ-1:0] hit_s;
  logic [3:0]      hit_cnt_s;
  logic [16:0]     sum_s;
  logic [15:0]     score_s;
  logic [15:0]     score_r;
  logic            cover_s;
  logic [11:0]     colour_s;
  logic [11:0]     rgb_r;

  function automatic logic [9:0] reset_y(input int idx);
    reset_y = 10'((Y0 + idx * Y_SPACING) % YWRAP);
  endfunction

  // YWRAP itself is never stored: the step that would reach it lands on 0 instead.
  function automatic logic [9:0] next_y(input logic [9:0] y);
    if (int'(y) + 32'sd1 == YWRAP) next_y = 10'd0;
    else                           next_y = y + 10'd1;
  endfunction

  function automatic logic covers(input logic [9:0] y, input int idx,
                                  input logic [9:0] h, input logic [9:0] v);
    int x_lo;
    x_lo   = X0 + idx * X_STEP;
    covers = (int'(h) >= x_lo) && (int'(h) < x_lo + OBJ_W) &&
             (int'(v) >= int'(y)) && (int'(v) <= int'(y) + OBJ_H);
  endfunction

  function automatic logic in_window(input logic [9:0] y);
    in_window = (int'(y) >= HIT_LO) && (int'(y) <= HIT_HI);
  endfunction

  function automatic logic [11:0] palette(input logic [CIDXW:0] idx);
    logic [31:0] idx_w;
    idx_w = 32'(idx);
    case (idx_w)
      32'd2:   palette = 12'hFA5;
      32'd3:   palette = 12'hF69;
      32'd4:   palette = 12'hB48;
      32'd5:   palette = 12'h8BE;
      32'd6:   palette = 12'h45A;
      32'd7:   palette = 12'h437;
      32'd8:   palette = 12'h000;
      default: palette = 12'hEEE;
    endcase
  endfunction

`ifdef SCORE_BCD_EN
  // Decimal add of a small hit count; bit 16 flags carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
    logic [4:0] d;
    logic       c;
    c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, a[4*k +: 4]} + ((k == 0) ? {1'b0, b} : 5'd0) + {4'd0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      bcd_add[4*k +: 4] = d[3:0];
    end
    bcd_add[16] = c;
  endfunction
`endif

  // Motion divider: one-cycle tick every SPEED_DIV clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               div_r <= '0;
    else if (div_r == DIV_LAST) div_r <= '0;
    else                        div_r <= div_r + DIVW'(1);
  end

  assign tick_s  = (div_r == DIV_LAST);
  assign press_s = sync2_r & ~sync2_d_r;

  // Button synchroniser and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      sync2_d_r <= 1'b0;
    end else begin
      sync1_r   <= button;
      sync2_r   <= sync1_r;
      sync2_d_r <= sync2_r;
    end
  end

  // Obstacle positions and hit-FSM state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NOBJ; i++) begin
        obj_y_r[i]     <= reset_y(i);
        hit_state_r[i] <= ST_ARMED;
      end
    end else begin
      for (int i = 0; i < NOBJ; i++) begin
        obj_y_r[i]     <= tick_s ? next_y(obj_y_r[i]) : obj_y_r[i];
        hit_state_r[i] <= hit_state_s[i];
      end
    end
  end

  // Hit FSM next state; evaluated on the pre-tick Y so a coincident tick cannot move a hit out of the window.
  always_comb begin
    hit_cnt_s = 4'd0;
    for (int i = 0; i < NOBJ; i++) begin
      hit_state_s[i] = hit_state_r[i];
      hit_s[i]       = 1'b0;
      case (hit_state_r[i])
        ST_ARMED: begin
          if (press_s && in_window(obj_y_r[i])) begin
            hit_state_s[i] = ST_SCORED;
            hit_s[i]       = 1'b1;
          end else begin
            hit_state_s[i] = ST_ARMED;
          end
        end
        ST_SCORED: begin
          if (int'(obj_y_r[i]) <= REARM_Y) hit_state_s[i] = ST_ARMED;
          else                              hit_state_s[i] = ST_SCORED;
        end
        default: hit_state_s[i] = ST_ARMED;
      endcase
      hit_cnt_s = hit_cnt_s + 4'(hit_s[i]);
    end
  end

  // Saturating score accumulation of all hits landing this cycle.
  always_comb begin
`ifdef SCORE_BCD_EN
    sum_s = bcd_add(score_r, hit_cnt_s);
    if (sum_s[16]) score_s = 16'h9999;
    else           score_s = sum_s[15:0];
`else
    sum_s = {1'b0, score_r} + {13'd0, hit_cnt_s};
    if (sum_s[16]) score_s = 16'hFFFF;
    else           score_s = sum_s[15:0];
`endif
  end

  // Score register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) score_r <= 16'h0000;
    else          score_r <= score_s;
  end

  // Colour priority: blanking, then obstacles, then sprite palette, then background.
  always_comb begin
    cover_s = 1'b0;
    for (int i = 0; i < NOBJ; i++) begin
      cover_s = cover_s | covers(obj_y_r[i], i, hCount, vCount);
    end
    if (!bright)      colour_s = 12'h000;
    else if (cover_s) colour_s = 12'h0F0;
    else if (drawing) colour_s = palette(pix);
    else              colour_s = 12'hEEE;
  end

  // Registered colour output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb_r <= 12'h000;
    else          rgb_r <= colour_s;
  end

  for (genvar g = 0; g < NOBJ; g++) begin : g_pack
    assign obj_y[10*g +: 10] = obj_y_r[g];
  end

  assign rgb   = rgb_r;
  assign score = score_r;

endmodule

// File: tb/tb_vga_obstacle_mapper.sv
// Self-checking bench for vga_obstacle_mapper: colour vector table with an RGB scoreboard,
// plus hand sequences for motion/wrap, button hits, mid-frame reset and score saturation.
module tb_vga_obstacle_mapper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bright = 1'b0;
  logic        drawing = 1'b0;
  logic [3:0]  pix = 4'd0;
  logic [9:0]  hCount = 10'd0;
  logic [9:0]  vCount = 10'd0;
  logic        button = 1'b0;
  logic [11:0] rgb;
  logic [15:0] score;
  logic [29:0] obj_y;
  logic [11:0] rgb2;
  logic [15:0] score2;
  logic [19:0] obj_y2;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int bad779 = 0;
  logic [11:0] exp_q [$];

`ifdef SCORE_BCD_EN
  localparam int SAT    = 32'h9999;
  localparam int AFTER9 = 32'h0010;
`else
  localparam int SAT    = 32'hFFFF;
  localparam int AFTER9 = 32'h000A;
`endif

  vga_obstacle_mapper #(.SPEED_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .bright(bright), .drawing(drawing), .pix(pix),
    .hCount(hCount), .vCount(vCount), .button(button),
    .rgb(rgb), .score(score), .obj_y(obj_y)
  );

  // Second instance: two obstacles 30 lines apart, so both sit in the hit window together.
  vga_obstacle_mapper #(.SPEED_DIV(4), .NOBJ(2), .Y_SPACING(30)) dut2 (
    .clk(clk), .reset_n(reset_n), .bright(bright), .drawing(drawing), .pix(pix),
    .hCount(hCount), .vCount(vCount), .button(button),
    .rgb(rgb2), .score(score2), .obj_y(obj_y2)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; obstacle Y = reset Y + ncyc/4 (mod 779).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ncyc <= 0;
    else          ncyc <= ncyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (obj_y[10*i +: 10] == 10'd779) bad779 <= bad779 + 1;
    for (int i = 0; i < 2; i++) if (obj_y2[10*i +: 10] == 10'd779) bad779 <= bad779 + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, ncyc);
    end
  endtask

  function automatic int exp_y(input int yr);
    return (yr + ncyc / 4) % 779;
  endfunction

  task automatic check_y(input string name);
    check({name, "_y0"}, int'(obj_y[9:0]),   exp_y(320));
    check({name, "_y1"}, int'(obj_y[19:10]), exp_y(420));
    check({name, "_y2"}, int'(obj_y[29:20]), exp_y(520));
    check({name, "_d2y0"}, int'(obj_y2[9:0]),   exp_y(320));
    check({name, "_d2y1"}, int'(obj_y2[19:10]), exp_y(350));
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (ncyc < n && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    check("run_to", ncyc, n);
  endtask

  typedef struct {
    bit b;
    bit d;
    int pix;
    int h;
    int v;
    bit rel;
    int exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    // Colour table; rel=1 means vCount is relative to obstacle 0's current Y.
    vecs = '{
      '{1'b1, 1'b1, 2,  10,  5,  1'b0, 32'hFA5},
      '{1'b0, 1'b1, 2,  10,  5,  1'b0, 32'h000},
      '{1'b1, 1'b1, 9,  10,  5,  1'b0, 32'hEEE},
      '{1'b1, 1'b1, 0,  10,  5,  1'b0, 32'hEEE},
      '{1'b1, 1'b1, 1,  10,  5,  1'b0, 32'hEEE},
      '{1'b1, 1'b1, 3,  10,  5,  1'b0, 32'hF69},
      '{1'b1, 1'b1, 4,  10,  5,  1'b0, 32'hB48},
      '{1'b1, 1'b1, 5,  10,  5,  1'b0, 32'h8BE},
      '{1'b1, 1'b1, 6,  10,  5,  1'b0, 32'h45A},
      '{1'b1, 1'b1, 7,  10,  5,  1'b0, 32'h437},
      '{1'b1, 1'b1, 8,  10,  5,  1'b0, 32'h000},
      '{1'b1, 1'b0, 3,  10,  5,  1'b0, 32'hEEE},
      '{1'b1, 1'b1, 15, 10,  5,  1'b0, 32'hEEE},
      '{1'b0, 1'b0, 0,  10,  5,  1'b0, 32'h000},
      '{1'b1, 1'b1, 2,  340, 0,  1'b1, 32'h0F0},
      '{1'b1, 1'b1, 2,  379, 40, 1'b1, 32'h0F0},
      '{1'b1, 1'b1, 2,  380, 0,  1'b1, 32'hFA5},
      '{1'b1, 1'b1, 2,  345, 41, 1'b1, 32'hFA5},
      '{1'b1, 1'b1, 2,  339, 10, 1'b1, 32'hFA5},
      '{1'b0, 1'b1, 2,  345, 10, 1'b1, 32'h000}
    };

    repeat (3) @(negedge clk);
    check("rst_rgb", int'(rgb), 0);
    check("rst_rgb2", int'(rgb2), 0);
    check("rst_score", int'(score), 0);
    check_y("rst");
    check("rst_y2_const", int'(obj_y[29:20]), 520);
    reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      int yc;
      logic [11:0] e;
      @(negedge clk);
      yc      = exp_y(320);
      bright  = vecs[k].b;
      drawing = vecs[k].d;
      pix     = 4'(vecs[k].pix);
      hCount  = 10'(vecs[k].h);
      vCount  = 10'(vecs[k].rel ? yc + vecs[k].v : vecs[k].v);
      exp_q.push_back(12'(vecs[k].exp));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rgb_vec%0d", k), int'(rgb), int'(e));
      end
    end
    bright = 1'b0;

    run_to(40);
    check_y("move40");

    // Single hit: button rises after edge 360, press acts on edge 363.
    run_to(360);
    button = 1'b1;
    run_to(362);
    check("score_edge2", int'(score), 0);
    run_to(363);
    check("score_edge3", int'(score), 1);
    check("score2_double", int'(score2), 2);
    run_to(410);
    check("score_held", int'(score), 1);
    check("score2_held", int'(score2), 2);
    button = 1'b0;
    run_to(420);
    button = 1'b1;
    run_to(430);
    check("score_not_rearmed", int'(score), 1);
    check("score2_not_rearmed", int'(score2), 2);
    button = 1'b0;

    // Wrap: 777 -> 778 after four clocks -> 0 after four more.
    run_to(1831);
    check("wrap_777", int'(obj_y[9:0]), 777);
    run_to(1832);
    check("wrap_778", int'(obj_y[9:0]), 778);
    run_to(1835);
    check("wrap_hold778", int'(obj_y[9:0]), 778);
    run_to(1836);
    check("wrap_0", int'(obj_y[9:0]), 0);
    check_y("wrap");

    // Second lap: obstacles re-armed near the top, hit again at Y=410.
    run_to(3476);
    check_y("lap2");
    button = 1'b1;
    run_to(3478);
    check("lap2_pre", int'(score), 1);
    run_to(3479);
    check("lap2_score", int'(score), 2);
    check("lap2_score2", int'(score2), 4);
    run_to(3485);
    button  = 1'b0;
    bright  = 1'b1;
    drawing = 1'b1;
    pix     = 4'd2;
    hCount  = 10'd10;
    vCount  = 10'd5;
    run_to(3488);
    check("pre_reset_rgb", int'(rgb), 32'hFA5);

    // Mid-cycle asynchronous reset, held for several edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rgb", int'(rgb), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_score2", int'(score2), 0);
    check_y("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_rgb", int'(rgb), 0);
    check("rst_hold_score", int'(score), 0);
    check_y("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    bright  = 1'b0;

    // Saturation / digit carry with preset scores.
    run_to(360);
    force dut.score_r = 16'h0009;
    force dut2.score_r = 16'(SAT);
    #1;
    release dut.score_r;
    release dut2.score_r;
    button = 1'b1;
    run_to(362);
    check("preset_score2", int'(score2), SAT);
    run_to(363);
    check("carry_score", int'(score), AFTER9);
    check("sat_score2", int'(score2), SAT);
    button = 1'b0;
    run_to(380);
    check("sat_hold", int'(score2), SAT);

    check("never_779", bad779, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
